// File: rtl/addsub_mw_seq_pkg.sv
// Shared types and constants for the multi-word add/sub sequencer.
// Holds the FSM encoding, the default slice width and the index sizing helper.
package addsub_mw_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int WIDTH_DEF = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addsub_mw_seq_slice.sv
// WIDTH-bit ripple add/sub slice: o_sum = a + (b ^ {sub}) + cin.
// The carry input doubles as the +1 of two's-complement subtraction.
module addsub_mw_seq_slice #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_add_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH-1:0] b_eff;

    always_comb begin
        b_eff = i_b ^ {WIDTH{i_add_sub}};
        {o_cout, o_sum} = {1'b0, i_a} + {1'b0, b_eff}
                        + {{WIDTH{1'b0}}, i_cin};
    end

endmodule

// File: rtl/addsub_mw_seq.sv
// Multi-word add/subtract sequencer: one WIDTH-bit slice time-shared
// over NWORDS words, LSW first, with the carry held between cycles.
module addsub_mw_seq
    import addsub_mw_seq_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int NWORDS = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_sub,
    input  logic [WIDTH*NWORDS-1:0] i_a,
    input  logic [WIDTH*NWORDS-1:0] i_b,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [WIDTH*NWORDS-1:0] o_result,
    output logic                    o_cout,
    output logic                    o_ovf
);

    localparam int W  = WIDTH * NWORDS;
    localparam int IW = idx_width(NWORDS);
    localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          sub_q, sub_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic [WIDTH-1:0] a_word;
    logic [WIDTH-1:0] b_word;
    logic [WIDTH-1:0] sum_w;
    logic             cout_w;

    assign a_word = a_q[idx_q*WIDTH +: WIDTH];
    assign b_word = b_q[idx_q*WIDTH +: WIDTH];

    addsub_mw_seq_slice #(
        .WIDTH(WIDTH)
    ) u_slice (
        .i_a      (a_word),
        .i_b      (b_word),
        .i_cin    (carry_q),
        .i_add_sub(sub_q),
        .o_sum    (sum_w),
        .o_cout   (cout_w)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        sub_d    = sub_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    sub_d   = i_sub;
                    carry_d = i_sub;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d[idx_q*WIDTH +: WIDTH] = sum_w;
                carry_d = cout_w;
                idx_d   = idx_q + IW'(1);
                // Publish only complete results; acc_d already holds the last word.
                if (idx_q == LAST) begin
                    state_d  = ST_DONE;
                    result_d = acc_d;
                    cout_d   = cout_w;
                    ovf_d    = (a_word[WIDTH-1] == (b_word[WIDTH-1] ^ sub_q))
                            && (sum_w[WIDTH-1] != a_word[WIDTH-1]);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            sub_q    <= sub_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_busy   = (state_q == ST_RUN);
    assign o_done   = (state_q == ST_DONE);
    assign o_result = result_q;
    assign o_cout   = cout_q;
    assign o_ovf    = ovf_q;

endmodule

// File: tb/tb_addsub_mw_seq.sv
// Bench for addsub_mw_seq: NWORDS=4 and NWORDS=1 instances,
// vector table, corner sequences and a queue-based scoreboard.
module tb_addsub_mw_seq;

    typedef struct {
        logic [31:0] r;
        logic        c;
        logic        v;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] r;
        logic        c;
        logic        v;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4, start4, sub4;
    logic [31:0] a4, b4, res4;
    logic        busy4, done4, cout4, ovf4;

    logic        rst1, start1, sub1;
    logic [7:0]  a1, b1, res1;
    logic        busy1, done1, cout1, ovf1;

    int checks = 0;
    int passes = 0;

    exp_t q4[$];
    exp_t q1[$];
    exp_t e4, e1;

    addsub_mw_seq #(.WIDTH(8), .NWORDS(4)) dut4 (
        .i_clk(clk), .i_rst(rst4), .i_start(start4), .i_sub(sub4),
        .i_a(a4), .i_b(b4), .o_busy(busy4), .o_done(done4),
        .o_result(res4), .o_cout(cout4), .o_ovf(ovf4)
    );

    addsub_mw_seq #(.WIDTH(8), .NWORDS(1)) dut1 (
        .i_clk(clk), .i_rst(rst1), .i_start(start1), .i_sub(sub1),
        .i_a(a1), .i_b(b1), .o_busy(busy1), .o_done(done1),
        .o_result(res1), .o_cout(cout1), .o_ovf(ovf1)
    );

    function automatic void chk(input string name,
                                input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input int nb);
        exp_t        e;
        logic [31:0] m, aa, bb;
        logic [32:0] s;
        m  = (nb == 32) ? 32'hFFFF_FFFF : ((32'h1 << nb) - 32'h1);
        aa = a & m;
        bb = (sub ? ~b : b) & m;
        s  = {1'b0, aa} + {1'b0, bb} + {32'h0, sub};
        e.r = s[31:0] & m;
        e.c = s[nb];
        e.v = (aa[nb-1] == bb[nb-1]) && (s[nb-1] != aa[nb-1]);
        return e;
    endfunction

    always @(negedge clk) begin
        if (done4) begin
            if (q4.size() == 0) chk("spurious_done4", 64'd1, 64'd0);
            else begin
                e4 = q4.pop_front();
                chk("res4", {30'd0, cout4, ovf4, res4}, {30'd0, e4.c, e4.v, e4.r});
            end
        end
        if (done1) begin
            if (q1.size() == 0) chk("spurious_done1", 64'd1, 64'd0);
            else begin
                e1 = q1.pop_front();
                chk("res1", {54'd0, cout1, ovf1, res1}, {54'd0, e1.c, e1.v, e1.r[7:0]});
            end
        end
    end

    task automatic drive(input int d, input logic st, input logic [31:0] a,
                         input logic [31:0] b, input logic sub);
        if (d == 4) begin
            start4 = st; a4 = a; b4 = b; sub4 = sub;
        end else begin
            start1 = st; a1 = a[7:0]; b1 = b[7:0]; sub1 = sub;
        end
    endtask

    task automatic wait_done(input int d, output int cyc);
        logic seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            seen = (d == 4) ? done4 : done1;
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input exp_t e);
        int cyc;
        @(posedge clk); #1;
        drive(d, 1'b1, a, b, sub);
        if (d == 4) q4.push_back(e);
        else q1.push_back(e);
        @(posedge clk); #1;
        drive(d, 1'b0, $urandom, $urandom, 1'($urandom));
        wait_done(d, cyc);
        chk("latency", 64'(cyc), (d == 4) ? 64'd5 : 64'd2);
    endtask

    initial begin
        vec_t        tbl[7];
        exp_t        e;
        logic [6:1]  busy_v, done_v;
        int          cyc, ndone;
        logic        hold_ok;
        logic [31:0] ra, rb;
        logic        rs;

        tbl[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        tbl[1] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        tbl[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[5] = '{32'h1234_5678, 32'h0FED_CBA8, 1'b0, 32'h2222_2220, 1'b0, 1'b0};
        tbl[6] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

        rst4 = 1'b1; rst1 = 1'b1;
        drive(4, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst4 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        chk("reset4", {28'd0, busy4, done4, cout4, ovf4, res4}, 64'd0);
        chk("reset1", {52'd0, busy1, done1, cout1, ovf1, res1}, 64'd0);

        // Latency and busy/done timing, start sampled at the next edge.
        @(posedge clk); #1;
        drive(4, 1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        q4.push_back('{32'h0000_0100, 1'b0, 1'b0});
        @(posedge clk); #1;
        drive(4, 1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            busy_v[k] = busy4;
            done_v[k] = done4;
        end
        chk("busy_pattern", 64'(busy_v), 64'(6'b001111));
        chk("done_pattern", 64'(done_v), 64'(6'b010000));

        for (int i = 0; i < 7; i++)
            run_op(4, tbl[i].a, tbl[i].b, tbl[i].sub, '{tbl[i].r, tbl[i].c, tbl[i].v});

        // Start pulse during RUN must be ignored.
        @(posedge clk); #1;
        drive(4, 1'b1, 32'h0000_0100, 32'h0000_0001, 1'b0);
        q4.push_back('{32'h0000_0101, 1'b0, 1'b0});
        @(posedge clk); #1;
        drive(4, 1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        drive(4, 1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 1'b1);
        @(posedge clk); #1;
        drive(4, 1'b0, 32'h0, 32'h0, 1'b0);
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done4) ndone++;
        end
        chk("ignore_start_in_run", 64'(ndone), 64'd1);

        // Back-to-back: start held during the DONE cycle.
        run_op(4, 32'h1234_5678, 32'h0FED_CBA8, 1'b0, '{32'h2222_2220, 1'b0, 1'b0});
        drive(4, 1'b1, 32'h0000_0005, 32'h0000_0003, 1'b1);
        q4.push_back('{32'h0000_0002, 1'b1, 1'b0});
        @(posedge clk); #1;
        drive(4, 1'b0, 32'h0, 32'h0, 1'b0);
        cyc = 0;
        hold_ok = 1'b1;
        done_v[1] = 1'b0;
        while (!done_v[1] && cyc < 40) begin
            @(negedge clk);
            cyc++;
            done_v[1] = done4;
            if (!done4 && res4 !== 32'h2222_2220) hold_ok = 1'b0;
        end
        chk("b2b_latency", 64'(cyc), 64'd5);
        chk("b2b_result_hold", 64'(hold_ok), 64'd1);

        // Reset in cycle 3 of an operation aborts it silently.
        @(posedge clk); #1;
        drive(4, 1'b1, 32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
        @(posedge clk); #1;
        drive(4, 1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        @(negedge clk);
        chk("reset_mid_op", {28'd0, busy4, done4, cout4, ovf4, res4}, 64'd0);
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done4) ndone++;
        end
        chk("no_done_after_abort", 64'(ndone), 64'd0);

        // Reset together with start: reset wins.
        @(posedge clk); #1;
        rst4 = 1'b1;
        drive(4, 1'b1, 32'h1, 32'h1, 1'b0);
        @(posedge clk); #1;
        rst4 = 1'b0;
        drive(4, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("reset_beats_start", {62'd0, busy4, done4}, 64'd0);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom);
            if (i % 8 == 0) rb = ra;
            e = model(ra, rb, rs, 32);
            run_op(4, ra, rb, rs, e);
        end

        run_op(1, 32'h7F, 32'h01, 1'b0, '{32'h80, 1'b0, 1'b1});
        run_op(1, 32'h00, 32'h01, 1'b1, '{32'hFF, 1'b0, 1'b0});
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom);
            e = model(ra, rb, rs, 8);
            run_op(1, ra, rb, rs, e);
        end

        repeat (3) @(negedge clk);
        chk("queues_drained", 64'(q4.size() + q1.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
